fft_r22sdf_twiddle: RTL

Pipelined complex twiddle-factor multiplier placed directly downstream of each `fft_r22sdf_bf` stage, except the last, in the R2²SDF FFT chain. It consumes the butterfly's data output and its `cnt_o` sample counter. It derives the twiddle exponent for the current sample, reads W from a ROM, and multiplies. It delivers the rotated sample, plus a counter re-aligned to the data, to the next `fft_r22sdf_bf` stage.

---
 rtl/fft_r22sdf_pkg.sv | 26 ++
 rtl/fft_r22sdf_twiddle_rom.sv | 57 +++++
 rtl/fft_r22sdf_twiddle.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fft_r22sdf_pkg.sv
// Shared definitions for the R2^2SDF FFT chain: twiddle index permutation,
// twiddle address derivation and the twiddle multiplier pipeline latency.
package fft_r22sdf_pkg;

    localparam int TWIDDLE_LAT = 4;

    // Twiddle exponent multiplier k for each butterfly sub-sequence m
    localparam logic [1:0] K_PERM [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

    function automatic logic [31:0] tw_addr(
        input logic [31:0] cnt,
        input int          stage,
        input int          nlog2
    );
        int          ls;
        logic [1:0]  m;
        logic [31:0] k;
        logic [31:0] n2;
        ls = nlog2 - 2 * stage;
        m  = 2'((cnt >> (ls - 2)) & 32'd3);
        k  = 32'(K_PERM[m]);
        n2 = cnt & ((32'd1 << (ls - 2)) - 32'd1);
        return (k * n2) << (2 * stage);
    endfunction

endpackage

// File: rtl/fft_r22sdf_twiddle_rom.sv
// Read-only twiddle table, {re, im} per word, with a registered read and no
// reset so that it maps onto block RAM.
module fft_r22sdf_twiddle_rom #(
    parameter int    TW      = 18,
    parameter int    FFT_N   = 1024,
    parameter string TW_FILE = "twiddle.hex",
    localparam int   DEPTH   = 3 * FFT_N / 4,
    localparam int   AW      = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic [AW-1:0]        addr_i,
    output logic signed [TW-1:0] w_re_o,
    output logic signed [TW-1:0] w_im_o
);

    localparam real PI_C    = 3.14159265358979323846;
    localparam real SCALE_C = real'((64'sd1 <<< (TW - 1)) - 64'sd1);

    logic [2*TW-1:0] mem [DEPTH];
    logic [2*TW-1:0] rd_d;
    logic [2*TW-1:0] rd_q;

    function automatic longint rnd_near(input real r);
        if (r >= 0.0) begin
            return longint'($floor(r + 0.5));
        end else begin
            return -longint'($floor(-r + 0.5));
        end
    endfunction

    // Table contents: W(a) = cos(2*pi*a/N) - j*sin(2*pi*a/N), scaled and rounded
    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            real    ang;
            longint wr;
            longint wi;
            ang = 2.0 * PI_C * real'(a) / real'(FFT_N);
            wr  = rnd_near($cos(ang) * SCALE_C);
            wi  = rnd_near(-$sin(ang) * SCALE_C);
            mem[a] = {TW'(wr), TW'(wi)};
        end
    end

    // Table lookup for the current address
    always_comb begin
        rd_d = mem[addr_i];
    end

    // Registered read port
    always_ff @(posedge clk_i) begin
        rd_q <= rd_d;
    end

    assign w_re_o = rd_q[2*TW-1:TW];
    assign w_im_o = rd_q[TW-1:0];

endmodule

// File: rtl/fft_r22sdf_twiddle.sv
// Four-stage pipelined twiddle rotation between two R2^2SDF butterfly stages:
// address/capture, ROM read, multiply, then round/saturate or exact bypass.
module fft_r22sdf_twiddle
    import fft_r22sdf_pkg::*;
#(
    parameter int    DW        = 25,
    parameter int    TW        = 18,
    parameter int    FFT_N     = 1024,
    parameter int    FFT_NLOG2 = 10,
    parameter int    STAGE     = 0,
    parameter int    STAGES    = 5,
    parameter string TW_FILE   = "twiddle.hex"
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [FFT_NLOG2-1:0]  cnt_i,
    input  logic                  valid_i,
    input  logic signed [DW-1:0]  x_re_i,
    input  logic signed [DW-1:0]  x_im_i,
    output logic [FFT_NLOG2-1:0]  cnt_o,
    output logic                  valid_o,
    output logic signed [DW-1:0]  z_re_o,
    output logic signed [DW-1:0]  z_im_o
);

    // The last butterfly stage has no rotation behind it
    localparam int STG = (STAGE < STAGES - 1) ? STAGE : STAGES - 2;
    localparam int AW  = $clog2(3 * FFT_N / 4);
    localparam int PW  = DW + TW;
    localparam int SW  = PW + 1;

    localparam logic signed [SW-1:0] RND_C     = SW'(64'sd1 <<< (TW - 2));
    localparam logic signed [SW-1:0] SAT_MAX_C = SW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN_C = SW'(-(64'sd1 <<< (DW - 1)));

    typedef struct packed {
        logic [FFT_NLOG2-1:0] cnt;
        logic                 vld;
        logic                 byp;
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } side_t;

    function automatic logic signed [DW-1:0] rnd_sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        r = (s + RND_C) >>> (TW - 1);
        if (r > SAT_MAX_C) begin
            return SAT_MAX_C[DW-1:0];
        end else if (r < SAT_MIN_C) begin
            return SAT_MIN_C[DW-1:0];
        end else begin
            return r[DW-1:0];
        end
    endfunction

    logic [31:0]          addr_full_s;
    logic [AW-1:0]        addr_d, addr_q;
    side_t                side0_d, side0_q, side1_d, side1_q, side2_d, side2_q;
    logic signed [TW-1:0] w_re_s, w_im_s;
    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [DW-1:0] z_re_d, z_im_d, z_re_q, z_im_q;
    logic [FFT_NLOG2-1:0] cnt_d, cnt_q;
    logic                 vld_d, vld_q;

    assign addr_full_s = tw_addr(32'(cnt_i), STG, FFT_NLOG2);

    fft_r22sdf_twiddle_rom #(
        .TW      (TW),
        .FFT_N   (FFT_N),
        .TW_FILE (TW_FILE)
    ) u_rom (
        .clk_i   (clk_i),
        .addr_i  (addr_q),
        .w_re_o  (w_re_s),
        .w_im_o  (w_im_s)
    );

    // Next-state logic for all four pipeline steps
    always_comb begin
        addr_d  = AW'(addr_full_s);
        side0_d = '{cnt: cnt_i, vld: valid_i, byp: (addr_full_s == 32'd0),
                    re: x_re_i, im: x_im_i};
        side1_d = side0_q;
        side2_d = side1_q;

        p_rr_d = PW'($signed(side1_q.re)) * PW'(w_re_s);
        p_ii_d = PW'($signed(side1_q.im)) * PW'(w_im_s);
        p_ri_d = PW'($signed(side1_q.re)) * PW'(w_im_s);
        p_ir_d = PW'($signed(side1_q.im)) * PW'(w_re_s);

        cnt_d = side2_q.cnt;
        vld_d = side2_q.vld;
        // W == 1 cannot be represented exactly, so pass x through untouched
        if (side2_q.byp) begin
            z_re_d = side2_q.re;
            z_im_d = side2_q.im;
        end else begin
            z_re_d = rnd_sat(SW'(p_rr_q) - SW'(p_ii_q));
            z_im_d = rnd_sat(SW'(p_ri_q) + SW'(p_ir_q));
        end
    end

    // Pipeline registers, cleared asynchronously so outputs drop at once
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q  <= '0;
            side0_q <= '0;
            side1_q <= '0;
            side2_q <= '0;
            p_rr_q  <= '0;
            p_ii_q  <= '0;
            p_ri_q  <= '0;
            p_ir_q  <= '0;
            z_re_q  <= '0;
            z_im_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            side0_q <= side0_d;
            side1_q <= side1_d;
            side2_q <= side2_d;
            p_rr_q  <= p_rr_d;
            p_ii_q  <= p_ii_d;
            p_ri_q  <= p_ri_d;
            p_ir_q  <= p_ir_d;
            z_re_q  <= z_re_d;
            z_im_q  <= z_im_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign valid_o = vld_q;
    assign z_re_o  = z_re_q;
    assign z_im_o  = z_im_q;

endmodule
